pulse_gen_2018: RTL
===================

Name: pulse_gen_2018

Overview:
- Synthetic detector-pulse source feeding the trapezoidal shaping filter input (same WIDTH sample bus, one sample per clock enable).
- On an accepted trigger, it emits a linear rise to a programmable amplitude, then an exponential decay with time constant 2^DECAY_SHIFT samples.
- Sits upstream of the filter in bench and on-chip self-test paths, providing known stimuli whose shaped response is predictable.

Parameters:
- WIDTH, 16 (from V2_param): output sample width, unsigned.
- RISE_SHIFT, 2: rise length = 2^RISE_SHIFT samples.
- DECAY_SHIFT, 3: decay per sample is acc -= acc >> DECAY_SHIFT.
- FRAC_BITS, 8: fractional bits in the internal accumulator.
- BASELINE, 0: constant offset added to every output sample.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  sample enable; all state advances only when ce=1.
- trig_valid  in  1  trigger request.
- trig_amp  in  WIDTH  peak amplitude, unsigned, sampled on acceptance.
- trig_ready  out  1  trigger can be accepted this cycle.
- out  out  WIDTH  sample to filter, registered.
- out_valid  out  1  registered copy of ce.
- busy  out  1  state != IDLE.
- done  out  1  one-clock pulse when a pulse fully decays.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, acc=0, cnt=0, target=0.
  - out=sat(BASELINE), out_valid=0, done=0.
- Internal widths: acc and target are WIDTH+FRAC_BITS+1 bits, unsigned. target = trig_amp << FRAC_BITS.
- Acceptance: occurs when trig_valid & trig_ready & ce. trig_ready = (state==IDLE), combinational from state.
- IDLE, on acceptance:
  - target <= trig_amp<<FRAC_BITS, step <= target>>RISE_SHIFT, cnt <= 0.
  - state <= RISE; acc unchanged (0).
- RISE, each ce:
  - cnt < 2^RISE_SHIFT-1: acc += step, cnt++.
  - cnt == 2^RISE_SHIFT-1: acc <= target exactly (removes truncation error), state <= DECAY.
  - The peak is the 2^RISE_SHIFT-th ce sample after acceptance.
- DECAY, each ce:
  - If (acc>>DECAY_SHIFT)==0: acc <= 0, state <= IDLE, done <= 1 for one clk.
  - Otherwise acc <= acc - (acc>>DECAY_SHIFT).
- Output, each ce: out <= sat(BASELINE + (acc_next>>FRAC_BITS)), clamped to 2^WIDTH-1. When ce=0, out holds.
- Latency: the first non-baseline sample appears on out at the ce edge following acceptance.
- trig_amp=0: the pulse runs normally (rise of zeros, immediate decay exit), and done still pulses.
- trig_valid while busy without the feature: ignored, no queueing.
- Reset mid-pulse: immediate return to reset values, no done pulse.
- ce=0 mid-pulse: state, cnt, acc and out are frozen; out_valid=0.

Optional Feature:
- Macro PULSE_GEN_PILEUP_EN.
- Defined:
  - trig_ready = (state==IDLE || state==DECAY).
  - Acceptance in DECAY starts a superimposed pulse: target <= sat(acc + (trig_amp<<FRAC_BITS)), step <= (trig_amp<<FRAC_BITS)>>RISE_SHIFT, cnt <= 0, state <= RISE, acc continues from its current value.
  - A saturated target clamps to (2^WIDTH-1)<<FRAC_BITS.
- Undefined: trig_ready only in IDLE; no pileup logic is synthesised.

Decomposition:
- Shared package (alongside V2_param):
  - typedef enum pg_state_t {PG_IDLE, PG_RISE, PG_DECAY}.
  - FRAC_BITS default.
  - Function sat_w(value) returning clamp to 2^WIDTH-1.
- One sub-module, pg_out_stage: registered saturating BASELINE adder plus FRAC_BITS truncation plus out_valid register.
- The FSM and accumulator stay in pulse_gen_2018.

Test Plan:
- Defaults, ce=1, trig_amp=1000 → out = 250, 500, 750, 1000, 875, 765, …; monotonic decay to 0; done pulses once; busy falls with done.
- Trigger while busy, feature undefined: trig_amp=500 at the 3rd decay sample → trig_ready=0, no change to the waveform.
- BASELINE=65000, trig_amp=1000 → out peaks and holds at 65535 while the sum exceeds it, then decays to 65000.
- Reset asserted at the 2nd decay sample, asynchronous → out=BASELINE, busy=0, done=0 immediately; a new trigger after release is accepted.
- ce toggling 1,0,0,1 during RISE with trig_amp=1000 → out sequence 250, hold, hold, 500; out_valid mirrors ce delayed one clk.
- PULSE_GEN_PILEUP_EN, trig_amp=1000 then 1000 at the 1st decay sample (acc=875) → rise continues from 875 with step 250, peaks at 1875, then decays.

Source files
------------

// File: rtl/pulse_gen_2018_pkg.sv
// Shared types and defaults for the synthetic detector-pulse source.
// Provides the FSM state enum, width defaults and the sat_w clamp helper.
package pulse_gen_2018_pkg;

    localparam int PG_WIDTH     = 16;
    localparam int PG_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_RISE,
        PG_DECAY
    } pg_state_t;

    // Clamp value to the largest w-bit unsigned number.
    function automatic logic [63:0] sat_w(
        input logic [63:0] value,
        input int          w
    );
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return (value > m) ? m : value;
    endfunction

endpackage

// File: rtl/pulse_gen_2018_out.sv
// pg_out_stage: registered saturating baseline adder for pulse_gen_2018.
// Ports: clk, reset, ce, acc_next (fixed point) -> out, out_valid.
module pg_out_stage
    import pulse_gen_2018_pkg::*;
#(
    parameter int WIDTH     = PG_WIDTH,
    parameter int FRAC_BITS = PG_FRAC_BITS,
    parameter int BASELINE  = 0,
    parameter int AW        = WIDTH + FRAC_BITS + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [AW-1:0] acc_next,
    output logic [WIDTH-1:0] out,
    output logic          out_valid
);

    localparam logic [WIDTH-1:0] RST_V =
        WIDTH'(sat_w(64'(BASELINE), WIDTH));

    logic [63:0] sum;

    always_comb begin
        sum = 64'(BASELINE) + 64'(acc_next >> FRAC_BITS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= RST_V;
            out_valid <= 1'b0;
        end else begin
            out_valid <= ce;
            if (ce)
                out <= WIDTH'(sat_w(sum, WIDTH));
        end
    end

endmodule

// File: rtl/pulse_gen_2018.sv
// pulse_gen_2018: triggered linear-rise / exponential-decay pulse source.
// Ports: clk, reset, ce, trig_valid, trig_amp, trig_ready, out, out_valid,
// busy, done. Macro PULSE_GEN_PILEUP_EN allows retrigger during decay.
module pulse_gen_2018
    import pulse_gen_2018_pkg::*;
#(
    parameter int WIDTH       = PG_WIDTH,
    parameter int RISE_SHIFT  = 2,
    parameter int DECAY_SHIFT = 3,
    parameter int FRAC_BITS   = PG_FRAC_BITS,
    parameter int BASELINE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             trig_valid,
    input  logic [WIDTH-1:0] trig_amp,
    output logic             trig_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int AW = WIDTH + FRAC_BITS + 1;
    localparam int CW = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << RISE_SHIFT) - 1);

    pg_state_t     state;
    logic [AW-1:0] acc;
    logic [AW-1:0] target;
    logic [AW-1:0] step;
    logic [AW-1:0] acc_nx;
    logic [AW-1:0] amp_f;
    logic [AW-1:0] decr;
    logic [CW-1:0] cnt;
    logic          accept;

    assign amp_f = AW'(trig_amp) << FRAC_BITS;
    assign decr  = acc >> DECAY_SHIFT;

`ifdef PULSE_GEN_PILEUP_EN
    localparam logic [AW-1:0] TGT_MAX =
        {1'b0, {WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};
    logic [AW-1:0] pile_sum;
    logic [AW-1:0] pile_tgt;
    assign trig_ready = (state == PG_IDLE) || (state == PG_DECAY);
    assign pile_sum   = acc + amp_f;
    assign pile_tgt   = (pile_sum > TGT_MAX) ? TGT_MAX : pile_sum;
`else
    assign trig_ready = (state == PG_IDLE);
`endif

    assign accept = trig_valid & trig_ready & ce;
    assign busy   = (state != PG_IDLE);

    // Final rise step snaps to target to drop the step truncation error.
    // An accepted pileup trigger holds acc for that sample.
    always_comb begin
        acc_nx = acc;
        unique case (state)
            PG_RISE:
                acc_nx = (cnt == CNT_LAST) ? target : acc + step;
            PG_DECAY:
                if (!accept)
                    acc_nx = (decr == '0) ? '0 : acc - decr;
            default:
                acc_nx = acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PG_IDLE;
            acc    <= '0;
            target <= '0;
            step   <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ce) begin
                acc <= acc_nx;
                unique case (state)
                    PG_IDLE: begin
                        if (accept) begin
                            target <= amp_f;
                            step   <= amp_f >> RISE_SHIFT;
                            cnt    <= '0;
                            state  <= PG_RISE;
                        end
                    end
                    PG_RISE: begin
                        if (cnt == CNT_LAST)
                            state <= PG_DECAY;
                        else
                            cnt <= cnt + CW'(1);
                    end
                    PG_DECAY: begin
`ifdef PULSE_GEN_PILEUP_EN
                        if (accept) begin
                            target <= pile_tgt;
                            step   <= amp_f >> RISE_SHIFT;
                            cnt    <= '0;
                            state  <= PG_RISE;
                        end else if (decr == '0) begin
                            state <= PG_IDLE;
                            done  <= 1'b1;
                        end
`else
                        if (decr == '0) begin
                            state <= PG_IDLE;
                            done  <= 1'b1;
                        end
`endif
                    end
                    default: state <= PG_IDLE;
                endcase
            end
        end
    end

    pg_out_stage #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .BASELINE  (BASELINE),
        .AW        (AW)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .acc_next  (acc_nx),
        .out       (out),
        .out_valid (out_valid)
    );

endmodule
